// File: rtl/lsu.sv
// Load/store unit: turns one load or store request into one or two
// memory beats, positions store data on byte lanes, and aligns and
// extends load data. Word-crossing accesses are split in two beats
// when MISALIGNED_EN=1.
module lsu #(
    parameter int XLEN          = 32,
    parameter int ADDR_W        = 32,
    parameter int MISALIGNED_EN = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_req_valid,
    output logic                o_req_ready,
    input  logic                i_req_store,
    input  logic [2:0]          i_req_funct3,
    input  logic [ADDR_W-1:0]   i_req_addr,
    input  logic [XLEN-1:0]     i_req_wdata,
    input  logic [4:0]          i_req_rd,
    output logic                o_rsp_valid,
    input  logic                i_rsp_ready,
    output logic [XLEN-1:0]     o_rsp_rdata,
    output logic [4:0]          o_rsp_rd,
    output logic                o_rsp_err,
    output logic                o_mem_valid,
    input  logic                i_mem_ready,
    output logic                o_mem_we,
    output logic [ADDR_W-1:0]   o_mem_addr,
    output logic [XLEN/8-1:0]   o_mem_be,
    output logic [XLEN-1:0]     o_mem_wdata,
    input  logic                i_mem_rvalid,
    input  logic [XLEN-1:0]     i_mem_rdata
);
    localparam int NB    = XLEN / 8;
    localparam int OFF_W = $clog2(NB);
    localparam int SZ_W  = OFF_W + 2;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ISSUE0 = 3'd1;
    localparam logic [2:0] S_WAIT0  = 3'd2;
    localparam logic [2:0] S_ISSUE1 = 3'd3;
    localparam logic [2:0] S_WAIT1  = 3'd4;
    localparam logic [2:0] S_RESP   = 3'd5;

    // Request decode (combinational, used only when accepting in IDLE)
    logic [1:0]        w_sl;
    logic [SZ_W-1:0]   w_size;
    logic [OFF_W-1:0]  w_off;
    logic [NB-1:0]     w_lane;
    logic [XLEN-1:0]   w_bmask;
    logic              w_misal;
    logic              w_split;
    logic              w_illegal;
    logic [2*XLEN-1:0] w_wide_data;
    logic [2*NB-1:0]   w_wide_be;
    logic [ADDR_W-1:0] w_base;

    assign w_sl      = i_req_funct3[1:0];
    assign w_size    = SZ_W'(1) << w_sl;
    assign w_off     = i_req_addr[OFF_W-1:0];
    // A shift by size >= NB leaves all ones, i.e. every lane enabled.
    assign w_lane    = ~({NB{1'b1}} << w_size);
    assign w_misal   = (w_off & (w_size[OFF_W-1:0] - OFF_W'(1))) != '0;
    assign w_split   = ({2'b00, w_off} + w_size) > SZ_W'(NB);
    assign w_illegal = (i_req_funct3 == 3'b111)
                     || (i_req_store && i_req_funct3[2])
                     || ((XLEN == 32) && (i_req_funct3 == 3'b011 || i_req_funct3 == 3'b110))
                     || ((MISALIGNED_EN == 0) && w_misal);

    // Expand the lane mask into a bit mask covering size bytes.
    generate
        for (genvar gi = 0; gi < NB; gi++) begin : g_bmask
            assign w_bmask[gi*8 +: 8] = {8{w_lane[gi]}};
        end
    endgenerate

    assign w_wide_data = {XLEN'(0), i_req_wdata & w_bmask} << {w_off, 3'b000};
    assign w_wide_be   = {NB'(0), w_lane} << w_off;
    assign w_base      = {i_req_addr[ADDR_W-1:OFF_W], OFF_W'(0)};

    // State and captured request
    logic [2:0]        r_state;
    logic              r_store;
    logic              r_unsigned;
    logic              r_split;
    logic [OFF_W-1:0]  r_off;
    logic [XLEN-1:0]   r_bmask;
    logic [ADDR_W-1:0] r_addr1;
    logic [XLEN-1:0]   r_wdata_hi;
    logic [NB-1:0]     r_be_hi;
    logic [XLEN-1:0]   r_rbuf_lo;

    // Registered outputs
    logic              r_mem_valid;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [NB-1:0]     r_mem_be;
    logic [XLEN-1:0]   r_mem_wdata;
    logic              r_rsp_valid;
    logic [XLEN-1:0]   r_rsp_rdata;
    logic [4:0]        r_rsp_rd;
    logic              r_rsp_err;

    // Load alignment: the high half of the buffer is the incoming second
    // beat, the low half the stored first beat (or the only beat).
    logic [2*XLEN-1:0] w_rbuf;
    logic [2*XLEN-1:0] w_sh;
    logic [XLEN-1:0]   w_lo;
    logic [XLEN-1:0]   w_top;
    logic              w_sign;
    logic [XLEN-1:0]   w_ext;

    assign w_rbuf = (r_state == S_WAIT1) ? {i_mem_rdata, r_rbuf_lo}
                                         : {XLEN'(0), i_mem_rdata};
    assign w_sh   = w_rbuf >> {r_off, 3'b000};
    assign w_lo   = w_sh[XLEN-1:0];
    assign w_top  = r_bmask & ~(r_bmask >> 1);
    assign w_sign = ~r_unsigned & (|(w_lo & w_top));
    assign w_ext  = (w_lo & r_bmask) | ({XLEN{w_sign}} & ~r_bmask);

    // Transaction sequencer: accept, issue beats, collect read data, respond
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_store     <= 1'b0;
            r_unsigned  <= 1'b0;
            r_split     <= 1'b0;
            r_off       <= '0;
            r_bmask     <= '0;
            r_addr1     <= '0;
            r_wdata_hi  <= '0;
            r_be_hi     <= '0;
            r_rbuf_lo   <= '0;
            r_mem_valid <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_be    <= '0;
            r_mem_wdata <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_rd    <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_req_valid) begin
                        r_store    <= i_req_store;
                        r_unsigned <= i_req_funct3[2];
                        r_split    <= w_split;
                        r_off      <= w_off;
                        r_bmask    <= w_bmask;
                        r_addr1    <= w_base + ADDR_W'(NB);
                        r_wdata_hi <= w_wide_data[2*XLEN-1:XLEN];
                        r_be_hi    <= w_wide_be[2*NB-1:NB];
                        r_rsp_rd   <= i_req_rd;
                        if (w_illegal) begin
                            r_state     <= S_RESP;
                            r_rsp_valid <= 1'b1;
                            r_rsp_err   <= 1'b1;
                            r_rsp_rdata <= '0;
                        end else begin
                            r_state     <= S_ISSUE0;
                            r_mem_valid <= 1'b1;
                            r_mem_we    <= i_req_store;
                            r_mem_addr  <= w_base;
                            r_mem_be    <= w_wide_be[NB-1:0];
                            r_mem_wdata <= i_req_store ? w_wide_data[XLEN-1:0] : '0;
                        end
                    end
                end
                S_ISSUE0: begin
                    if (i_mem_ready) begin
                        r_mem_valid <= 1'b0;
                        if (!r_store) begin
                            r_state <= S_WAIT0;
                        end else if (r_split) begin
                            r_state <= S_ISSUE1;
                        end else begin
                            r_state     <= S_RESP;
                            r_rsp_valid <= 1'b1;
                            r_rsp_err   <= 1'b0;
                            r_rsp_rdata <= '0;
                        end
                    end
                end
                S_ISSUE1: begin
                    // Second beat is presented one cycle after entry.
                    if (!r_mem_valid) begin
                        r_mem_valid <= 1'b1;
                        r_mem_we    <= r_store;
                        r_mem_addr  <= r_addr1;
                        r_mem_be    <= r_be_hi;
                        r_mem_wdata <= r_store ? r_wdata_hi : '0;
                    end else if (i_mem_ready) begin
                        r_mem_valid <= 1'b0;
                        if (r_store) begin
                            r_state     <= S_RESP;
                            r_rsp_valid <= 1'b1;
                            r_rsp_err   <= 1'b0;
                            r_rsp_rdata <= '0;
                        end else begin
                            r_state <= S_WAIT1;
                        end
                    end
                end
                S_WAIT0: begin
                    if (i_mem_rvalid) begin
                        r_rbuf_lo <= i_mem_rdata;
                        if (r_split) begin
                            r_state <= S_ISSUE1;
                        end else begin
                            r_state     <= S_RESP;
                            r_rsp_valid <= 1'b1;
                            r_rsp_err   <= 1'b0;
                            r_rsp_rdata <= w_ext;
                        end
                    end
                end
                S_WAIT1: begin
                    if (i_mem_rvalid) begin
                        r_state     <= S_RESP;
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= 1'b0;
                        r_rsp_rdata <= w_ext;
                    end
                end
                S_RESP: begin
                    if (i_rsp_ready) begin
                        r_state     <= S_IDLE;
                        r_rsp_valid <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_req_ready = (r_state == S_IDLE);
    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_rdata = r_rsp_rdata;
    assign o_rsp_rd    = r_rsp_rd;
    assign o_rsp_err   = r_rsp_err;
    assign o_mem_valid = r_mem_valid;
    assign o_mem_we    = r_mem_we;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_be    = r_mem_be;
    assign o_mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: 32-bit unit with misalignment splitting,
// 32-bit unit without it, and a 64-bit unit.
module tb_lsu;
    logic        clk;
    logic        rst_n;

    // Shared request fields and main (XLEN=32, MISALIGNED_EN=1) unit
    logic        req_valid, req_ready, req_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic [4:0]  req_rd;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;
    logic [4:0]  rsp_rd;
    logic        mem_valid, mem_ready, mem_we, mem_rvalid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;

    // MISALIGNED_EN=0 unit
    logic        na_req_valid, na_req_ready, na_rsp_valid, na_rsp_ready, na_rsp_err;
    logic [31:0] na_rsp_rdata, na_mem_addr, na_mem_wdata;
    logic [4:0]  na_rsp_rd;
    logic        na_mem_valid, na_mem_we;
    logic [3:0]  na_mem_be;

    // XLEN=64 unit
    logic        d_req_valid, d_req_ready, d_rsp_valid, d_rsp_ready, d_rsp_err;
    logic [63:0] d_req_wdata, d_rsp_rdata, d_mem_wdata, d_mem_rdata;
    logic [4:0]  d_rsp_rd;
    logic        d_mem_valid, d_mem_we, d_mem_rvalid;
    logic [31:0] d_mem_addr;
    logic [7:0]  d_mem_be;

    int checks = 0;
    int errors = 0;

    lsu #(.XLEN(32), .ADDR_W(32), .MISALIGNED_EN(1)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_store(req_store),
        .i_req_funct3(req_funct3), .i_req_addr(req_addr), .i_req_wdata(req_wdata),
        .i_req_rd(req_rd), .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
        .o_rsp_rdata(rsp_rdata), .o_rsp_rd(rsp_rd), .o_rsp_err(rsp_err),
        .o_mem_valid(mem_valid), .i_mem_ready(mem_ready), .o_mem_we(mem_we),
        .o_mem_addr(mem_addr), .o_mem_be(mem_be), .o_mem_wdata(mem_wdata),
        .i_mem_rvalid(mem_rvalid), .i_mem_rdata(mem_rdata)
    );

    lsu #(.XLEN(32), .ADDR_W(32), .MISALIGNED_EN(0)) u_na (
        .clk(clk), .rst_n(rst_n),
        .i_req_valid(na_req_valid), .o_req_ready(na_req_ready), .i_req_store(req_store),
        .i_req_funct3(req_funct3), .i_req_addr(req_addr), .i_req_wdata(req_wdata),
        .i_req_rd(req_rd), .o_rsp_valid(na_rsp_valid), .i_rsp_ready(na_rsp_ready),
        .o_rsp_rdata(na_rsp_rdata), .o_rsp_rd(na_rsp_rd), .o_rsp_err(na_rsp_err),
        .o_mem_valid(na_mem_valid), .i_mem_ready(mem_ready), .o_mem_we(na_mem_we),
        .o_mem_addr(na_mem_addr), .o_mem_be(na_mem_be), .o_mem_wdata(na_mem_wdata),
        .i_mem_rvalid(mem_rvalid), .i_mem_rdata(mem_rdata)
    );

    lsu #(.XLEN(64), .ADDR_W(32), .MISALIGNED_EN(1)) u_d64 (
        .clk(clk), .rst_n(rst_n),
        .i_req_valid(d_req_valid), .o_req_ready(d_req_ready), .i_req_store(req_store),
        .i_req_funct3(req_funct3), .i_req_addr(req_addr), .i_req_wdata(d_req_wdata),
        .i_req_rd(req_rd), .o_rsp_valid(d_rsp_valid), .i_rsp_ready(d_rsp_ready),
        .o_rsp_rdata(d_rsp_rdata), .o_rsp_rd(d_rsp_rd), .o_rsp_err(d_rsp_err),
        .o_mem_valid(d_mem_valid), .i_mem_ready(mem_ready), .o_mem_we(d_mem_we),
        .o_mem_addr(d_mem_addr), .o_mem_be(d_mem_be), .o_mem_wdata(d_mem_wdata),
        .i_mem_rvalid(d_mem_rvalid), .i_mem_rdata(d_mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present one request to the main unit for one cycle; returns in cycle 1.
    task automatic send(input logic st, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input logic [4:0] rd);
        @(negedge clk);
        req_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd; req_rd = rd;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    // Bounded wait for a memory beat on the main unit.
    task automatic wait_mv(input string tag);
        int n = 0;
        while (!mem_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_mv"}, 64'(mem_valid), 64'd1);
    endtask

    task automatic load_beat(input string tag, input logic [31:0] ea, input logic [3:0] ebe,
                             input logic [31:0] data);
        wait_mv(tag);
        chk({tag, "_addr"}, 64'(mem_addr), 64'(ea));
        chk({tag, "_be"}, 64'(mem_be), 64'(ebe));
        chk({tag, "_we"}, 64'(mem_we), 64'd0);
        @(negedge clk);
        mem_rvalid = 1'b1; mem_rdata = data;
        @(negedge clk);
        mem_rvalid = 1'b0; mem_rdata = '0;
    endtask

    task automatic store_beat(input string tag, input logic [31:0] ea, input logic [3:0] ebe,
                              input logic [31:0] ewd);
        wait_mv(tag);
        chk({tag, "_addr"}, 64'(mem_addr), 64'(ea));
        chk({tag, "_be"}, 64'(mem_be), 64'(ebe));
        chk({tag, "_wdata"}, 64'(mem_wdata), 64'(ewd));
        chk({tag, "_we"}, 64'(mem_we), 64'd1);
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_store = 1'b0; req_funct3 = '0;
        req_addr = '0; req_wdata = '0; req_rd = '0; rsp_ready = 1'b1;
        mem_ready = 1'b1; mem_rvalid = 1'b0; mem_rdata = '0;
        na_req_valid = 1'b0; na_rsp_ready = 1'b1;
        d_req_valid = 1'b0; d_rsp_ready = 1'b1; d_req_wdata = '0;
        d_mem_rvalid = 1'b0; d_mem_rdata = '0;
        repeat (3) @(negedge clk);
        chk("rst_req_ready", 64'(req_ready), 64'd1);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
        chk("rst_mem_valid", 64'(mem_valid), 64'd0);
        chk("rst_mem_addr", 64'(mem_addr), 64'd0);
        chk("rst_mem_be", 64'(mem_be), 64'd0);
        chk("rst_mem_wdata", 64'(mem_wdata), 64'd0);
        rst_n = 1'b1;

        // SW 0x100, then hold rsp_ready low for 3 cycles
        rsp_ready = 1'b0;
        send(1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 5'd3);
        chk("sw_mv", 64'(mem_valid), 64'd1);
        chk("sw_addr", 64'(mem_addr), 64'h100);
        chk("sw_be", 64'(mem_be), 64'hF);
        chk("sw_wdata", 64'(mem_wdata), 64'hDEADBEEF);
        chk("sw_we", 64'(mem_we), 64'd1);
        chk("sw_busy", 64'(req_ready), 64'd0);
        @(negedge clk);
        chk("sw_rsp_c2", 64'(rsp_valid), 64'd1);
        chk("sw_err", 64'(rsp_err), 64'd0);
        chk("sw_rdata", 64'(rsp_rdata), 64'd0);
        chk("sw_mv_low", 64'(mem_valid), 64'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rsp_hold_valid", 64'(rsp_valid), 64'd1);
            chk("rsp_hold_rd", 64'(rsp_rd), 64'd3);
            chk("rsp_hold_rdata", 64'(rsp_rdata), 64'd0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("sw_done", 64'(rsp_valid), 64'd0);
        chk("sw_idle", 64'(req_ready), 64'd1);

        // LB / LBU at 0x203
        send(1'b0, 3'b000, 32'h203, 32'h0, 5'd7);
        load_beat("lb", 32'h200, 4'b1000, 32'h80000000);
        chk("lb_rsp", 64'(rsp_valid), 64'd1);
        chk("lb_rdata", 64'(rsp_rdata), 64'hFFFFFF80);
        chk("lb_rd", 64'(rsp_rd), 64'd7);
        send(1'b0, 3'b100, 32'h203, 32'h0, 5'd7);
        load_beat("lbu", 32'h200, 4'b1000, 32'h80000000);
        chk("lbu_rdata", 64'(rsp_rdata), 64'h00000080);
        chk("lbu_err", 64'(rsp_err), 64'd0);

        // Split LW at 0x102
        send(1'b0, 3'b010, 32'h102, 32'h0, 5'd1);
        load_beat("lw0", 32'h100, 4'b1100, 32'hAABBCCDD);
        load_beat("lw1", 32'h104, 4'b0011, 32'h11223344);
        chk("lw_rsp", 64'(rsp_valid), 64'd1);
        chk("lw_rdata", 64'(rsp_rdata), 64'h3344AABB);
        chk("lw_err", 64'(rsp_err), 64'd0);

        // Split SH at 0x107
        send(1'b1, 3'b001, 32'h107, 32'h00001234, 5'd2);
        store_beat("sh0", 32'h104, 4'b1000, 32'h34000000);
        store_beat("sh1", 32'h108, 4'b0001, 32'h00000012);
        chk("sh_rsp", 64'(rsp_valid), 64'd1);
        chk("sh_err", 64'(rsp_err), 64'd0);

        // funct3 011 on a 32-bit unit is illegal
        send(1'b0, 3'b011, 32'h0, 32'h0, 5'd9);
        chk("ld32_rsp_c1", 64'(rsp_valid), 64'd1);
        chk("ld32_err", 64'(rsp_err), 64'd1);
        chk("ld32_mv", 64'(mem_valid), 64'd0);
        chk("ld32_rdata", 64'(rsp_rdata), 64'd0);
        chk("ld32_rd", 64'(rsp_rd), 64'd9);

        // LH 0x101 with splitting disabled
        @(negedge clk);
        req_store = 1'b0; req_funct3 = 3'b001; req_addr = 32'h101; req_rd = 5'd4;
        na_req_valid = 1'b1;
        @(negedge clk);
        na_req_valid = 1'b0;
        chk("na_rsp_c1", 64'(na_rsp_valid), 64'd1);
        chk("na_err", 64'(na_rsp_err), 64'd1);
        chk("na_mv", 64'(na_mem_valid), 64'd0);

        // Store with mem_ready held low for 5 cycles
        mem_ready = 1'b0;
        send(1'b1, 3'b010, 32'h40, 32'h55667788, 5'd4);
        for (int i = 0; i < 5; i++) begin
            chk("bp_mv", 64'(mem_valid), 64'd1);
            chk("bp_addr", 64'(mem_addr), 64'h40);
            chk("bp_be", 64'(mem_be), 64'hF);
            chk("bp_wdata", 64'(mem_wdata), 64'h55667788);
            chk("bp_rsp", 64'(rsp_valid), 64'd0);
            @(negedge clk);
        end
        mem_ready = 1'b1;
        @(negedge clk);
        chk("bp_done", 64'(rsp_valid), 64'd1);

        // Reset during WAIT0, then a normal load
        send(1'b0, 3'b010, 32'h300, 32'h0, 5'd5);
        chk("rw_mv", 64'(mem_valid), 64'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rw_req_ready", 64'(req_ready), 64'd1);
        chk("rw_mem_addr", 64'(mem_addr), 64'd0);
        chk("rw_mem_be", 64'(mem_be), 64'd0);
        chk("rw_mem_we", 64'(mem_we), 64'd0);
        chk("rw_rsp_valid", 64'(rsp_valid), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        send(1'b0, 3'b010, 32'h104, 32'h0, 5'd6);
        load_beat("post", 32'h104, 4'b1111, 32'hCAFEF00D);
        chk("post_rdata", 64'(rsp_rdata), 64'hCAFEF00D);
        chk("post_rd", 64'(rsp_rd), 64'd6);

        // LD 0x8 on the 64-bit unit
        @(negedge clk);
        req_store = 1'b0; req_funct3 = 3'b011; req_addr = 32'h8; req_rd = 5'd8;
        d_req_valid = 1'b1;
        @(negedge clk);
        d_req_valid = 1'b0;
        chk("ld64_mv", 64'(d_mem_valid), 64'd1);
        chk("ld64_addr", 64'(d_mem_addr), 64'h8);
        chk("ld64_be", 64'(d_mem_be), 64'hFF);
        @(negedge clk);
        chk("ld64_single", 64'(d_mem_valid), 64'd0);
        d_mem_rvalid = 1'b1; d_mem_rdata = 64'h8877665544332211;
        @(negedge clk);
        d_mem_rvalid = 1'b0;
        chk("ld64_rsp", 64'(d_rsp_valid), 64'd1);
        chk("ld64_rdata", d_rsp_rdata, 64'h8877665544332211);
        chk("ld64_err", 64'(d_rsp_err), 64'd0);

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
